// File: rtl/bcd_key_counter_pkg.sv
// Shared constants for the BCD key counter: segment codes, key indices,
// the resolved-operation enum and the 7-segment encoder.
package bcd_key_counter_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Pushbutton assignment on KEY[3:0]
  localparam int unsigned KEY_INC  = 0;
  localparam int unsigned KEY_DEC  = 1;
  localparam int unsigned KEY_LOAD = 2;
  localparam int unsigned KEY_CLR  = 3;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CLR,
    OP_LOAD,
    OP_INC,
    OP_DEC
  } op_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_E;
    endcase
  endfunction

endpackage

// File: rtl/bcd_key_counter_if.sv
// Board-side bundle of the BCD key counter: switches, keys and display outputs.
interface bcd_key_counter_if #(
  parameter int unsigned DIGITS = 4
);
  logic [9:0]          SW;
  logic [3:0]          KEY;
  logic [7*DIGITS-1:0] HEX;
  logic [4*DIGITS-1:0] BCD;
  logic                WRAP;

  modport master (output SW, KEY, input HEX, BCD, WRAP);
  modport slave  (input SW, KEY, output HEX, BCD, WRAP);
endinterface

// File: rtl/bcd_key_counter_key_debounce.sv
// One pushbutton: 2-FF synchroniser, level debouncer and press pulse.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);
  localparam int unsigned CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          key_meta;
  logic          key_sync;
  logic          stable;
  logic [CW-1:0] cnt;

  // Synchronise, qualify the new level for DEB_CYCLES clocks, pulse on 1->0
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      stable   <= 1'b1;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      key_meta <= key;
      key_sync <= key_meta;
      press    <= 1'b0;
      if (key_sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= key_sync;
        cnt    <= '0;
        press  <= stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_key_counter.sv
// Multi-digit BCD up/down counter driven by debounced pushbuttons,
// with registered 7-segment outputs.
module bcd_key_counter
  import bcd_key_counter_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned SAT_MODE   = 0,
  parameter int unsigned BLANK_LZ   = 0
) (
  input logic               CLOCK_50,
  input logic               RESET,
  bcd_key_counter_if.slave  bus
);

  logic [3:0]          press;
  logic [9:0]          sw_meta;
  logic [9:0]          sw_sync;
  logic [2:0]          sw_idx;
  logic [3:0]          sw_clamp;
  logic                sw_unused;
  op_t                 op;
  logic [4*DIGITS-1:0] bcd;
  logic [4*DIGITS-1:0] inc_val;
  logic [4*DIGITS-1:0] dec_val;
  logic [4*DIGITS-1:0] load_val;
  logic                all9;
  logic                all0;
  logic                carry;
  logic                borrow;
  logic [3:0]          dig;
  logic [7*DIGITS-1:0] hex;
  logic [7*DIGITS-1:0] hex_next;
  logic                seen_nz;
  logic [3:0]          hdig;
  int unsigned         hpos;
  logic                wrap;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (CLOCK_50),
      .rst   (RESET),
      .key   (bus.KEY[k]),
      .press (press[k])
    );
  end

  // Switches are quasi-static but still asynchronous, so bring them across too
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= bus.SW;
      sw_sync <= sw_meta;
    end
  end

  assign sw_idx    = sw_sync[9:7];
  assign sw_clamp  = (sw_sync[3:0] > 4'd9) ? 4'd9 : sw_sync[3:0];
  assign sw_unused = ^sw_sync[6:4];

  // Priority resolution of same-cycle press events
  always_comb begin
    op = OP_NONE;
    if      (press[KEY_CLR])  op = OP_CLR;
    else if (press[KEY_LOAD]) op = OP_LOAD;
    else if (press[KEY_INC])  op = OP_INC;
    else if (press[KEY_DEC])  op = OP_DEC;
  end

  // Candidate next counts: full carry/borrow ripple plus limit detection
  always_comb begin
    inc_val = bcd;
    dec_val = bcd;
    carry   = 1'b1;
    borrow  = 1'b1;
    all9    = 1'b1;
    all0    = 1'b1;
    dig     = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig = bcd[4*i +: 4];
      if (dig != 4'd9) all9 = 1'b0;
      if (dig != 4'd0) all0 = 1'b0;
      if (carry) begin
        if (dig >= 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = dig + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (dig == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = dig - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Load replaces one digit; an index beyond the display leaves the count alone
  always_comb begin
    load_val = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sw_idx == 3'(i)) load_val[4*i +: 4] = sw_clamp;
    end
  end

  // Segment image of the current count, scanned from the top digit down
  always_comb begin
    hex_next = '0;
    seen_nz  = 1'b0;
    hdig     = '0;
    hpos     = 0;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      hpos = DIGITS - 1 - j;
      hdig = bcd[4*hpos +: 4];
      if (hdig != 4'd0) seen_nz = 1'b1;
      if (BLANK_LZ != 0 && !seen_nz && hpos != 0)
        hex_next[7*hpos +: 7] = SEG_BLANK;
      else
        hex_next[7*hpos +: 7] = seg_encode(hdig);
    end
  end

  // Count register, wrap pulse and display register
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      bcd  <= '0;
      wrap <= 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++)
        hex[7*i +: 7] <= (BLANK_LZ != 0 && i != 0) ? SEG_BLANK : SEG_0;
    end else begin
      wrap <= 1'b0;
      hex  <= hex_next;
      case (op)
        OP_CLR:  bcd <= '0;
        OP_LOAD: bcd <= load_val;
        OP_INC: begin
          if (all9 && SAT_MODE != 0) begin
            wrap <= 1'b1;
          end else begin
            bcd  <= inc_val;
            wrap <= all9;
          end
        end
        OP_DEC: begin
          if (all0 && SAT_MODE != 0) begin
            wrap <= 1'b1;
          end else begin
            bcd  <= dec_val;
            wrap <= all0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.BCD  = bcd;
  assign bus.HEX  = hex;
  assign bus.WRAP = wrap;

endmodule

// File: doc/bcd_key_counter.md
BCD_KEY_COUNTER -- requirements
Module: bcd_key_counter

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits and 7-segment displays, legal range 1..8.
REQ-002 Parameter DEB_CYCLES, default 500000 (10 ms at 50 MHz): debounce qualification length in clocks, minimum 2.
REQ-003 Parameter SAT_MODE, default 0: 0 = wrap at limits, 1 = saturate at limits.
REQ-004 Parameter BLANK_LZ, default 0: 1 = blank leading-zero digits.
REQ-005 One clock, CLOCK_50; reset RESET is synchronous and active-high; no other clock or reset.
REQ-006 CLOCK_50  input  1  system clock; all state updates on the rising edge.
REQ-007 RESET  input  1  synchronous, active-high reset.
REQ-008 SW  input  10  SW[3:0] load value, SW[9:7] target digit index; asynchronous to CLOCK_50.
REQ-009 KEY  input  4  active-low pushbuttons, asynchronous: KEY[0] increment, KEY[1] decrement, KEY[2] load, KEY[3] clear.
REQ-010 HEX  output  7*DIGITS  registered active-low segments; HEX[7i+6:7i] is digit i, digit 0 least significant.
REQ-011 BCD  output  4*DIGITS  registered current count, 4 bits per digit.
REQ-012 WRAP  output  1  one-cycle pulse on wrap, or on a blocked step when saturating.

Function
REQ-013 Each KEY bit: 2-FF synchroniser, then debouncer holding a stable level and a counter.
- Counter clears whenever the synchronised level equals the stable level.
- Otherwise the counter increments; on reaching DEB_CYCLES-1 the stable level takes the new value and the counter clears.
REQ-014 A press event is a one-cycle pulse on a stable 1->0 transition; releases generate no event; a held key yields exactly one event.
REQ-015 Timing: a KEY low held steadily from cycle t produces the press event in cycle t+DEB_CYCLES+2 (+/-1); a glitch shorter than DEB_CYCLES produces no event.
REQ-016 Same-cycle events resolve by priority clear > load > increment > decrement; lower-priority events in that cycle are dropped.
REQ-017 Clear: all digits become 0 in the next cycle.
REQ-018 Load: digit SW[9:7] becomes min(SW[3:0], 9); other digits unchanged; index >= DIGITS means no change.
REQ-019 Increment: decimal +1 with carry ripple across all digits, completing in one cycle.
REQ-020 Decrement: decimal -1 with borrow ripple across all digits, completing in one cycle.
REQ-021 SAT_MODE=0: all-9s +1 gives all-0s; all-0s -1 gives all-9s; either case pulses WRAP.
REQ-022 SAT_MODE=1: +1 at all-9s and -1 at all-0s leave the count unchanged and pulse WRAP.
REQ-023 BCD updates one cycle after the event; HEX updates one cycle after BCD (two-cycle event-to-display latency).
REQ-024 Segment codes 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-025 A non-BCD digit value displays 0000110 ("E"); blanked digits display 1111111.
REQ-026 BLANK_LZ=1: blank every zero digit above the most significant nonzero digit; digit 0 is never blanked.

Reset
REQ-027 While RESET is high at a clock edge:
- BCD = 0; WRAP = 0.
- HEX shows 0 on all digits, or 0 on digit 0 and blank elsewhere when BLANK_LZ=1.
- Synchroniser and stable levels = 1 (released); debounce counters = 0.
REQ-028 Reset mid-debounce discards the pending press; a key still held after reset is released must requalify through a full debounce, giving one event.

Structure
REQ-029 A shared package holds the 7-segment code constants (digits 0..9, E, BLANK) and the KEY index constants.
REQ-030 One sub-module, key_debounce (sync + debounce + press pulse, parameter DEB_CYCLES), instantiated four times.
REQ-031 Digit decoding is a package function or generate loop, not a further sub-module.

Verification
REQ-032 Bench runs DEB_CYCLES=4, DIGITS=4 and drives:
- KEY[0] press from 0000 -> BCD 0001; HEX[6:0] = 1111001 two cycles after the event.
- SAT_MODE=0, count 9999, KEY[0] -> 0000 with a single WRAP pulse; count 0000, KEY[1] -> 9999 with WRAP.
- SAT_MODE=1, count 0000, KEY[1] -> BCD stays 0000, WRAP pulses once.
- SW[9:7]=2, SW[3:0]=12, KEY[2] -> BCD 0900; then KEY[3] -> 0000.
- 3-cycle KEY[0] glitch -> no change; KEY[0] held 100 cycles -> exactly one increment.
- RESET asserted mid-debounce of KEY[1] -> no decrement; BCD 0000; BLANK_LZ=1 -> HEX digits 3..1 = 1111111.
